// File: rtl/rsa_pkg.sv
// Shared RSA datapath constants and the control-state encoding used by
// n0prime_param and the Montgomery multiplier.
package rsa_pkg;

   localparam int RSA_N_W = 1024;
   localparam int RSA_W   = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } rsa_state_e;

endpackage : rsa_pkg

// File: rtl/n0prime_param.sv
// Computes n0' = -n^-1 mod 2^W (or +n^-1) one bit per cycle: each step adds
// n << i to an accumulator whenever its bit i is still zero.
module n0prime_param
   import rsa_pkg::*;
#(
   parameter int N_W = RSA_N_W,
   parameter int W   = RSA_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N_W-1:0] n,
   input  logic           inv_mode,
   output logic [W-1:0]   n0prime,
   output logic           done,
   output logic           busy,
   output logic           err
);

   localparam int             I_W    = $clog2(W) + 1;
   localparam logic [I_W-1:0] I_LAST = I_W'(W - 1);

   rsa_state_e     state_reg, state_next;
   logic [W-1:0]   n_lat_reg, n_lat_next;
   logic           inv_lat_reg, inv_lat_next;
   logic           odd_lat_reg, odd_lat_next;
   logic [W-1:0]   t_reg, t_next;
   logic [W-1:0]   x_reg, x_next;
   logic [I_W-1:0] i_reg, i_next;
   logic [W-1:0]   result_reg, result_next;
   logic [W-1:0]   n0prime_reg, n0prime_next;
   logic           done_reg, done_next;
   logic           err_reg, err_next;

   logic           accept;
   logic [W-1:0]   t_step;

   // Only the low word of n matters; the upper bits are deliberately dropped.
   generate
      if (N_W > W) begin : g_n_hi
         logic n_hi_unused;
         assign n_hi_unused = ^n[N_W-1:W];
      end
   endgenerate

   // A request landing on the done cycle is refused even though the FSM is idle.
   assign accept = (state_reg == ST_IDLE) && start && !done_reg;
   assign t_step = t_reg + (n_lat_reg << i_reg);

   always_comb begin
      state_next   = state_reg;
      n_lat_next   = n_lat_reg;
      inv_lat_next = inv_lat_reg;
      odd_lat_next = odd_lat_reg;
      t_next       = t_reg;
      x_next       = x_reg;
      i_next       = i_reg;
      result_next  = result_reg;
      n0prime_next = n0prime_reg;
      done_next    = 1'b0;
      err_next     = err_reg;

      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               n_lat_next   = n[W-1:0];
               inv_lat_next = inv_mode;
               odd_lat_next = n[0];
               err_next     = 1'b0;
               if (n[0]) begin
                  t_next     = '0;
                  x_next     = '0;
                  i_next     = '0;
                  state_next = ST_CALC;
               end else begin
                  result_next = '0;
                  state_next  = ST_DONE;
               end
            end
         end

         ST_CALC: begin
            if (!t_reg[i_reg[I_W-2:0]]) begin
               t_next = t_step;
               x_next = x_reg | (W'(1) << i_reg);
            end
            i_next = i_reg + 1'b1;
            // Load the result from the final x so DONE starts with it ready.
            if (i_reg == I_LAST) begin
               result_next = inv_lat_reg ? (~x_next + W'(1)) : x_next;
               state_next  = ST_DONE;
            end
         end

         ST_DONE: begin
            n0prime_next = odd_lat_reg ? result_reg : '0;
            err_next     = !odd_lat_reg;
            done_next    = 1'b1;
            state_next   = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         n_lat_reg   <= '0;
         inv_lat_reg <= 1'b0;
         odd_lat_reg <= 1'b0;
         t_reg       <= '0;
         x_reg       <= '0;
         i_reg       <= '0;
         result_reg  <= '0;
         n0prime_reg <= '0;
         done_reg    <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         n_lat_reg   <= n_lat_next;
         inv_lat_reg <= inv_lat_next;
         odd_lat_reg <= odd_lat_next;
         t_reg       <= t_next;
         x_reg       <= x_next;
         i_reg       <= i_next;
         result_reg  <= result_next;
         n0prime_reg <= n0prime_next;
         done_reg    <= done_next;
         err_reg     <= err_next;
      end
   end

   assign n0prime = n0prime_reg;
   assign done    = done_reg;
   assign err     = err_reg;
   assign busy    = (state_reg != ST_IDLE) || done_reg;

endmodule : n0prime_param

// File: tb/tb_n0prime_param.sv
// Directed bench for n0prime_param: known inverses, even-modulus error path,
// mid-run reset and back-to-back requests with held start.
module tb_n0prime_param;

   localparam int N_W = 1024;
   localparam int W   = 32;

   logic           clk;
   logic           rst;
   logic           start;
   logic [N_W-1:0] n;
   logic           inv_mode;
   logic [W-1:0]   n0prime;
   logic           done;
   logic           busy;
   logic           err;

   int checks_cnt = 0;
   int errors_cnt = 0;

   n0prime_param #(.N_W(N_W), .W(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .n        (n),
      .inv_mode (inv_mode),
      .n0prime  (n0prime),
      .done     (done),
      .busy     (busy),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [N_W-1:0] rand_wide();
      logic [N_W-1:0] v;
      for (int j = 0; j < N_W / 32; j++) v[j*32 +: 32] = $urandom;
      return v;
   endfunction

   // One request; inputs are scrambled right after acceptance.
   task automatic run_req(input string tag, input logic [N_W-1:0] nv, input logic inv,
                          input logic [W-1:0] exp_res, input logic exp_err, input int exp_cyc);
      int cyc;
      logic [W-1:0] res;
      @(negedge clk);
      n = nv; inv_mode = inv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = ~nv; inv_mode = ~inv;
      check({tag, "_busy_start"}, 64'(busy), 64'd1);
      cyc = -1;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk); #1;
         if (done) begin
            cyc = c + 1;
            break;
         end
      end
      res = n0prime;
      $display("req %s: n_lo=0x%08h inv=%0d -> n0prime=0x%08h err=%0d cycles=%0d",
               tag, nv[W-1:0], inv, res, err, cyc);
      check({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
      check({tag, "_n0prime"}, 64'(res), 64'(exp_res));
      check({tag, "_err"}, 64'(err), 64'(exp_err));
      if (cyc > 0) begin
         check({tag, "_busy_done"}, 64'(busy), 64'd1);
         @(posedge clk); #1;
         check({tag, "_done_pulse"}, 64'(done), 64'd0);
         check({tag, "_busy_after"}, 64'(busy), 64'd0);
         check({tag, "_hold"}, 64'(n0prime), 64'(exp_res));
         check({tag, "_err_hold"}, 64'(err), 64'(exp_err));
      end
   endtask

   initial begin
      logic [N_W-1:0] nv;
      logic [W-1:0]   n_acc, prod;
      int             dones, cyc;

      rst = 1'b1; start = 1'b0; n = '0; inv_mode = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_n0prime", 64'(n0prime), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      rst = 1'b0;

      // Known vectors.
      nv = '0; nv[0] = 1'b1;
      run_req("n1", nv, 1'b0, 32'hFFFF_FFFF, 1'b0, 34);
      nv = '0; nv[W-1:0] = 32'd3;
      run_req("n3_neg", nv, 1'b0, 32'h5555_5555, 1'b0, 34);
      run_req("n3_pos", nv, 1'b1, 32'hAAAA_AAAB, 1'b0, 34);
      nv = rand_wide(); nv[W-1:0] = 32'hFFFF_FFFF;
      run_req("nff_a", nv, 1'b0, 32'h0000_0001, 1'b0, 34);
      nv = rand_wide(); nv[W-1:0] = 32'hFFFF_FFFF;
      run_req("nff_b", nv, 1'b0, 32'h0000_0001, 1'b0, 34);
      nv = rand_wide(); nv[W-1:0] = 32'd2;
      run_req("n2_even", nv, 1'b0, 32'h0, 1'b1, 2);
      nv = rand_wide(); nv[W-1:0] = 32'd5;
      run_req("n5_neg", nv, 1'b0, 32'h3333_3333, 1'b0, 34);
      nv = '0; nv[W-1:0] = 32'd7;
      run_req("n7_pos", nv, 1'b1, 32'hB6DB_6DB7, 1'b0, 34);

      // Reset while iteration 10 is in progress.
      @(negedge clk);
      n = '0; n[W-1:0] = 32'd3; inv_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_n0prime", 64'(n0prime), 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_err", 64'(err), 64'd0);
      rst = 1'b0;
      dones = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      $display("req midrst: dones after abandoned run=%0d", dones);
      check("midrst_no_done", 64'(dones), 64'd0);
      nv = '0; nv[W-1:0] = 32'd3;
      run_req("n3_after_rst", nv, 1'b0, 32'h5555_5555, 1'b0, 34);

      // Back-to-back requests with start held high and inputs toggling.
      @(negedge clk);
      start = 1'b1; inv_mode = 1'b0;
      for (int r = 0; r < 4; r++) begin
         n_acc = $urandom | 32'd1;
         if (r > 0) begin
            // Done cycle: start must be ignored here, offer an even value.
            n = rand_wide(); n[0] = 1'b0; inv_mode = 1'b1;
            @(posedge clk); #1;
            check("b2b_done_pulse", 64'(done), 64'd0);
            check("b2b_idle_busy", 64'(busy), 64'd0);
         end
         n = rand_wide(); n[W-1:0] = n_acc; inv_mode = 1'b0;
         @(posedge clk); #1;
         cyc = -1;
         for (int c = 1; c <= 100; c++) begin
            n = rand_wide(); inv_mode = c[0];
            @(posedge clk); #1;
            if (done) begin
               cyc = c + 1;
               break;
            end
         end
         if (r == 3) start = 1'b0;
         prod = n_acc * n0prime;
         $display("req b2b%0d: n_lo=0x%08h -> n0prime=0x%08h err=%0d cycles=%0d",
                  r, n_acc, n0prime, err, cyc);
         check("b2b_cycles", 64'(cyc), 64'd34);
         check("b2b_product", 64'(prod), 64'hFFFF_FFFF);
         check("b2b_err", 64'(err), 64'd0);
      end
      dones = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      check("b2b_no_extra_done", 64'(dones), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
      $finish;
   end

endmodule : tb_n0prime_param

// File: doc/n0prime_param.md
N0PRIME_PARAM -- requirements
Module: n0prime_param

Interface
REQ-001 Parameter N_W, default 1024: width of modulus input n; SHALL be at least W.
REQ-002 Parameter W, default 32: Montgomery word width; legal values 16, 32 and 64.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 n  input  N_W  modulus; only n[W-1:0] is used; sampled on the accepted start.
REQ-007 inv_mode  input  1  0 selects -n^-1 mod 2^W; 1 selects +n^-1 mod 2^W; sampled on the accepted start.
REQ-008 n0prime  output  W  result; held stable from done until the next accepted start.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 busy  output  1  high from the cycle after an accepted start until the cycle done is high, inclusive.
REQ-011 err  output  1  high together with done when the latched n is even; holds until the next accepted start.

Function
REQ-012 States SHALL be IDLE, CALC and DONE.
REQ-013 IDLE with start=1: latch n[W-1:0], inv_mode and n[0].
  - n[0]=1: clear accumulator t and result x, zero iteration counter i, go to CALC.
  - n[0]=0: go directly to DONE with err=1.
REQ-014 CALC, one iteration per cycle, i = 0..W-1:
  - if t[i]=0, set x[i]=1 and t <= t + (n_lat << i), truncated to W bits;
  - otherwise t and x are unchanged.
REQ-015 CALC SHALL move to DONE after the iteration with i=W-1; the counter SHALL be ceil(log2(W))+1 bits wide with no wrap inside CALC.
REQ-016 On entering DONE, the register feeding n0prime SHALL load:
  - x when inv_mode_lat=0;
  - (~x + 1) mod 2^W when inv_mode_lat=1;
  - all zeros when err=1.
REQ-017 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-018 Latency for odd n: start sampled at edge k; done high in the cycle after edge k+W+1, i.e. W+2 cycles from start to done.
REQ-019 Latency for even n: done high in the cycle after edge k+1.
REQ-020 start while busy=1 or done=1 SHALL be ignored; the running computation and the latched inputs are unaffected.
REQ-021 start in the same cycle as done SHALL be ignored; a new request is accepted only once the block is back in IDLE.
REQ-022 Changes on n or inv_mode after acceptance SHALL NOT affect the result.
REQ-023 Arithmetic is modulo 2^W throughout; all carries out of bit W-1 are discarded.
REQ-024 The block SHALL contain no multiplier or divider; each iteration is one W-bit adder plus a mux.

Reset
REQ-025 rst=1 SHALL force state to IDLE and set n0prime=0, done=0, busy=0, err=0; the internal t, x and i SHALL also be cleared.
REQ-026 rst SHALL take priority over start and may be asserted in any state; a computation interrupted mid-CALC is abandoned and produces no done.
REQ-027 The first start SHALL be accepted in the cycle after rst deasserts.

Structure
REQ-028 Default N_W and W and the state encoding SHALL live in the shared package rsa_pkg, for reuse by the Montgomery multiplier.
REQ-029 The block SHALL be a single module with no sub-module; the iteration step is inline logic.

Verification (W=32, N_W=1024)
REQ-030 n=...0001, inv_mode=0 -> n0prime=0xFFFFFFFF, err=0, done exactly 34 cycles after start.
REQ-031 n=...0003, inv_mode=0 -> n0prime=0x55555555; repeat with inv_mode=1 -> n0prime=0xAAAAAAAB.
REQ-032 n low word=0xFFFFFFFF with random upper bits, inv_mode=0 -> n0prime=0x00000001, independent of the upper bits.
REQ-033 n=...0002 -> err=1, n0prime=0, done 2 cycles after start; the next odd request completes normally with err=0.
REQ-034 Assert rst at iteration 10 of CALC -> no done, all outputs 0; a fresh start with n=3 gives 0x55555555.
REQ-035 Random odd n with start held high and n toggling while busy -> exactly one done per accepted request, and (n * n0prime) mod 2^32 = 0xFFFFFFFF for the latched n.
